// File: rtl/br_gshare_predictor.sv
// br_gshare_predictor: gshare branch direction predictor with 2-bit counter PHT and init walker
module br_gshare_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic                 pred_ready,
  input  logic                 br_update,
  input  logic                 br_taken,
  input  logic [31:0]          br_pc,
  output logic [HIST_BITS-1:0] ghr_out
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [INDEX_BITS-1:0] init_idx, ghr_ext, f_idx, u_idx;
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS:0] ghr_shift;
  logic [1:0] pht [2**INDEX_BITS];
  logic [1:0] cnt, cnt_nxt;
  logic upd, unused_bits;
  assign ghr_out = ghr;
  assign pred_ready = state == RUN;
  assign upd = pred_ready && br_update;
  assign ghr_ext = INDEX_BITS'(ghr);
  assign ghr_shift = {ghr, br_taken};
  assign f_idx = fetch_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign u_idx = br_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign unused_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0], br_pc[31:INDEX_BITS+2], br_pc[1:0]};
  // Walker finishes after writing the last entry; counter saturates in both directions
  always_comb begin
    state_nxt = (state == INIT && &init_idx) ? RUN : state;
    cnt = pht[u_idx];
    cnt_nxt = br_taken ? (&cnt ? cnt : cnt + 2'd1) : (|cnt ? cnt - 2'd1 : cnt);
  end
  // Control state, history register and the registered prediction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      init_idx <= '0;
      ghr <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_idx <= init_idx + INDEX_BITS'(1);
      pred_valid <= pred_ready && fetch_valid;
      pred_taken <= pred_ready && fetch_valid && pht[f_idx][1];
      if (upd) ghr <= ghr_shift[HIST_BITS-1:0];
    end
  end
  // Table storage: init walk writes weakly-not-taken, run mode writes the trained counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) pht[init_idx] <= 2'b01;
      else if (upd) pht[u_idx] <= cnt_nxt;
    end
  end
endmodule
